// File: rtl/kevin_scan_if.sv
// kevin_scan_if: minterm stream port of the truth-table scanner.
//   m_valid  minterm code is valid
//   m_code   minterm code, N bits, ascending order within a scan
//   m_ready  consumer accepts m_code when m_valid && m_ready at a rising edge
// The master modport is the scanner side and the slave modport is the consumer side.
interface kevin_scan_if #(
  parameter int N = 4
);
  logic         m_valid;
  logic [N-1:0] m_code;
  logic         m_ready;

  modport master (output m_valid, output m_code, input m_ready);
  modport slave  (input m_valid, input m_code, output m_ready);
endinterface

// File: rtl/kevin_scan.sv
// kevin_scan: sequential truth-table scanner for 4-input, 1-output functions.
// It drives every code onto the function under test, samples the response at
// the end of each settle window, builds the 2**N-entry truth table, and then
// streams the minterm codes out through the m interface.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  begin a scan (accepted only in IDLE)
//   probe  code driven to the function under test
//   resp   function output, sampled at settle-end edges only
//   busy   scan in progress (SWEEP or EMIT)
//   done   one-cycle completion pulse
//   mask   captured truth table, bit i = response for code i
//   ones   number of 1s in mask
//   match  mask == EXPECTED, valid from done until the next start
//   m      minterm stream (master side)
//
// state | meaning
// IDLE  | waiting for start; mask/ones/match hold the last results
// SWEEP | probe = code, sample resp after SETTLE cycles, step through all codes
// EMIT  | walk the table; offer each set entry as a minterm code
// DONE  | one-cycle done pulse, match registered
module kevin_scan #(
  parameter int              N        = 4,
  parameter int              SETTLE   = 2,
  parameter logic [2**N-1:0] EXPECTED = 16'h56E2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N-1:0]    probe,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] mask,
  output logic [N:0]      ones,
  output logic            match,
  kevin_scan_if.master    m
);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT, DONE} state_t;

  localparam logic [N-1:0] LAST    = '1;
  localparam logic [3:0]   CNT_END = 4'(SETTLE - 1);

  state_t          state, state_n;
  // code doubles as the probe code in SWEEP and the table index in EMIT
  logic [N-1:0]    code, code_n;
  logic [3:0]      cnt, cnt_n;
  logic [2**N-1:0] mask_n;
  logic [N:0]      ones_n;
  logic            match_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code  <= '0;
      cnt   <= '0;
      mask  <= '0;
      ones  <= '0;
      match <= 1'b0;
    end else begin
      state <= state_n;
      code  <= code_n;
      cnt   <= cnt_n;
      mask  <= mask_n;
      ones  <= ones_n;
      match <= match_n;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    cnt_n   = cnt;
    mask_n  = mask;
    ones_n  = ones;
    match_n = match;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SWEEP;
          code_n  = '0;
          cnt_n   = '0;
          mask_n  = '0;
          ones_n  = '0;
          match_n = 1'b0;
        end
      end
      SWEEP: begin
        if (cnt == CNT_END) begin
          cnt_n        = '0;
          mask_n[code] = resp;
          ones_n       = ones + {{N{1'b0}}, resp};
          if (code == LAST) begin
            state_n = EMIT;
            code_n  = '0;
          end else begin
            code_n = code + 1'b1;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      EMIT: begin
        // Zero entries take one cycle; set entries wait for the handshake.
        if (!mask[code] || m.m_ready) begin
          if (code == LAST) begin
            state_n = DONE;
            match_n = (mask == EXPECTED);
          end else begin
            code_n = code + 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign probe     = (state == SWEEP) ? code : '0;
  assign busy      = (state == SWEEP) || (state == EMIT);
  assign done      = (state == DONE);
  assign m.m_valid = (state == EMIT) && mask[code];
  assign m.m_code  = (state == EMIT) ? code : '0;

endmodule

// File: tb/tb_kevin_scan.sv
module tb_kevin_scan;
  localparam int S = 2;
  localparam logic [15:0] REF = 16'h56E2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  probe;
  logic        resp;
  logic        busy, done, match;
  logic [15:0] mask;
  logic [4:0]  ones;

  kevin_scan_if #(.N(4)) bus ();

  kevin_scan #(.N(4), .SETTLE(S), .EXPECTED(REF)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe), .resp(resp),
    .busy(busy), .done(done), .mask(mask), .ones(ones), .match(match),
    .m(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the function under test is a table; the scan outcome
  // follows from it directly.
  logic [15:0] tbl = 16'h0;
  bit          active = 0;
  int          t0 = 0;
  int          stall_n = 0;
  logic [15:0] hold_mask = 0;
  int          hold_ones = 0;
  bit          hold_match = 0;
  int          q[$];
  int          acc[$];
  bit          prev_hold = 0;
  logic [3:0]  prev_code = 0;

  assign resp = tbl[probe];
  initial bus.m_ready = 1'b1;

  function automatic bit target(input int c);
    return c inside {1, 5, 6, 7, 9, 10, 12, 14};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare, after the stimulus of this negedge has settled.
  initial begin
    int e, k, done_e;
    logic [15:0] em;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_hold = 0;
      end else begin
        e = active ? (cyc - t0) : -1;
        done_e = 16 * S + 16 + stall_n;
        if (e < 0) begin
          chk("idle_probe", probe, 0);
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_valid", bus.m_valid, 0);
          chk("idle_code", bus.m_code, 0);
          chk("idle_mask", mask, hold_mask);
          chk("idle_ones", ones, hold_ones);
          chk("idle_match", match, hold_match);
        end else if (e < 16 * S) begin
          k = e / S;
          em = tbl & 16'((32'd1 << k) - 1);
          chk("sweep_probe", probe, k);
          chk("sweep_busy", busy, 1);
          chk("sweep_done", done, 0);
          chk("sweep_valid", bus.m_valid, 0);
          chk("sweep_mask", mask, em);
          chk("sweep_ones", ones, $countones(em));
          chk("sweep_match", match, 0);
        end else if (e < done_e) begin
          chk("emit_probe", probe, 0);
          chk("emit_busy", busy, 1);
          chk("emit_done", done, 0);
          chk("emit_mask", mask, tbl);
          chk("emit_ones", ones, $countones(tbl));
          if (bus.m_valid) begin
            if (prev_hold) chk("code_stable", bus.m_code, prev_code);
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL stream_extra: got code %0d want no more codes", bus.m_code);
            end else begin
              chk("stream_code", bus.m_code, q[0]);
            end
            if (bus.m_ready) begin
              acc.push_back(int'(bus.m_code));
              if (q.size() > 0) void'(q.pop_front());
            end
          end
          prev_hold = bus.m_valid && !bus.m_ready;
          prev_code = bus.m_code;
        end else begin
          chk("done_pulse", done, 1);
          chk("done_busy", busy, 0);
          chk("done_valid", bus.m_valid, 0);
          chk("done_mask", mask, tbl);
          chk("done_ones", ones, $countones(tbl));
          chk("done_match", match, (tbl == REF));
          chk("stream_left", q.size(), 0);
          hold_mask = tbl;
          hold_ones = $countones(tbl);
          hold_match = (tbl == REF);
          active = 0;
          prev_hold = 0;
        end
      end
    end
  end

  int done_at;

  task automatic begin_scan(input logic [15:0] t, input int stall);
    tbl = t;
    stall_n = (t != 0) ? stall : 0;
    q.delete();
    acc.delete();
    for (int i = 0; i < 16; i++) if (t[i]) q.push_back(i);
    done_at = -1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    active = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input logic [15:0] t, input int stall, input bit repulse);
    int n, lowleft;
    bit stalled;
    begin_scan(t, stall);
    n = 0;
    lowleft = 0;
    stalled = 0;
    while (active && n < 300) begin
      @(negedge clk);
      n++;
      start = (repulse && (n == 5 || n == 6)) ? 1'b1 : 1'b0;
      if (done && done_at < 0) done_at = cyc - t0;
      if (lowleft > 0) begin
        lowleft--;
        if (lowleft == 0) bus.m_ready = 1'b1;
      end else if (stall > 0 && !stalled && bus.m_valid) begin
        stalled = 1;
        bus.m_ready = 1'b0;
        lowleft = stall;
      end
    end
    start = 1'b0;
    bus.m_ready = 1'b1;
    if (active) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no done within %0d cycles want done", n);
      active = 0;
    end
  endtask

  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    active = 0;
    hold_mask = 0;
    hold_ones = 0;
    hold_match = 0;
    q.delete();
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_probe", probe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", mask, 0);
    chk("rst_ones", ones, 0);
    chk("rst_match", match, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_code", bus.m_code, 0);
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_mask"}, mask, 16'h56E2);
    chk({tag, "_ones"}, ones, 8);
    chk({tag, "_match"}, match, 1);
    chk({tag, "_done_at"}, done_at, 48);
    chk({tag, "_count"}, acc.size(), 8);
    if (acc.size() == 8) begin
      int lit[8] = '{1, 5, 6, 7, 9, 10, 12, 14};
      for (int i = 0; i < 8; i++) chk({tag, "_seq"}, acc[i], lit[i]);
    end
  endtask

  initial begin
    logic [15:0] target_tbl;
    int n;
    for (int i = 0; i < 16; i++) target_tbl[i] = target(i);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random activity, then a 2-cycle reset.
    begin_scan(16'($urandom), 0);
    repeat (10) @(negedge clk);
    apply_reset(2);

    // Nominal scan.
    run_scan(target_tbl, 0, 0);
    check_nominal("nom");

    // Backpressure on the first minterm.
    run_scan(target_tbl, 5, 0);
    chk("bp_done_at", done_at, 53);
    chk("bp_count", acc.size(), 8);
    if (acc.size() > 0) chk("bp_first", acc[0], 1);

    // Faulty function: code 0 reads 1.
    run_scan(target_tbl | 16'h0001, 0, 0);
    chk("fault_mask", mask, 16'h56E3);
    chk("fault_ones", ones, 9);
    chk("fault_match", match, 0);
    if (acc.size() > 0) chk("fault_first", acc[0], 0);

    // All-zero and all-one functions.
    run_scan(16'h0000, 0, 0);
    chk("zero_ones", ones, 0);
    chk("zero_done_at", done_at, 48);
    chk("zero_count", acc.size(), 0);
    run_scan(16'hFFFF, 0, 0);
    chk("ones_mask", mask, 16'hFFFF);
    chk("ones_ones", ones, 16);
    chk("ones_done_at", done_at, 48);
    chk("ones_count", acc.size(), 16);
    for (int i = 0; i < acc.size(); i++) chk("ones_seq", acc[i], i);

    // start re-pulsed during SWEEP has no effect.
    run_scan(target_tbl, 0, 1);
    check_nominal("repulse");

    // Reset while probe == 7, then a fresh scan.
    begin_scan(target_tbl, 0);
    n = 0;
    while (probe != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("probe7_reached", probe, 7);
    apply_reset(1);
    run_scan(target_tbl, 0, 0);
    check_nominal("after_rst");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t want finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/kevin_scan.md
# kevin_scan

Sequential truth-table scanner for the lab-1 4-input single-output functions. It drives every input code onto a combinational function under test and samples that function's 1-bit output after a settle delay. From the samples it builds the full 16-entry truth table, then streams the recovered minterm codes out over a valid/ready port. It is the reading side of the `in`/`out` interface used by the lab-1 function implementations, and gives the bench and board top a single checker for all of them.

## Interface
- N, 4, width of probe code; table depth is 2**N.
- SETTLE, 2, cycles from a probe change to its response sample; legal range 1..15.
- EXPECTED, 16'h56E2, reference truth table, bit i = function value for input code i (minterms 1,5,6,7,9,10,12,14).

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- probe  out  N  input code driven to the function under test (its `in`).
- resp  in  1  function output (its `out`), sampled at the end of each settle window.
- busy  out  1  high from the edge accepting start until done.
- done  out  1  one-cycle pulse at scan completion.
- mask  out  2**N  captured truth table, bit i = resp sampled for code i.
- ones  out  N+1  count of 1s in mask (0..16).
- match  out  1  mask == EXPECTED; valid from done until the next start.
- m_valid  out  1  minterm stream valid.
- m_code  out  N  minterm code, ascending order.
- m_ready  in  1  minterm stream ready.

## Operation
- States:
  - IDLE: busy=0, probe=0, m_valid=0. start=1 → SWEEP. On this transition: code=0, settle counter=0, mask=0, ones=0, match=0.
  - SWEEP: probe=code. The counter increments each cycle. On the edge where the counter reaches SETTLE-1:
    - mask[code]<=resp, ones<=ones+resp, counter<=0.
    - If code==15 → EMIT with index i=0; otherwise code<=code+1.
  - EMIT: m_valid = mask[i], m_code = i.
    - If mask[i]==0, advance i after 1 cycle.
    - If mask[i]==1, hold i until m_valid&&m_ready, then advance.
    - After index 15 is resolved → DONE.
  - DONE: one cycle. done=1, busy=0, match registered (mask==EXPECTED) → IDLE.
- Width rules:
  - code and i are N bits and do not wrap inside a scan; the terminal test is ==15.
  - ones is N+1 bits and cannot overflow.
- start while busy is ignored; there is no queueing.
- mask, ones, and match hold their values after done until the next accepted start clears them.
- m_ready while m_valid=0 has no effect. m_code is stable while m_valid=1 && m_ready=0.
- rst (any state, including mid-SWEEP or mid-EMIT) → IDLE on that edge. All outputs 0: probe, busy, done, mask, ones, match, m_valid, m_code. Any scan in progress is discarded.

## Timing
- start high at edge T0 → busy=1 and probe=0 after T0.
- Code c is sampled at edge T0+(c+1)*SETTLE, and probe advances on the same edge.
- The last sample is at T0+16*SETTLE; EMIT begins after it.
- EMIT takes 16 cycles plus all cycles where m_valid=1 && m_ready=0.
- With m_ready tied high:
  - done=1 and busy=0 in the cycle after edge T0+16*SETTLE+16.
  - For SETTLE=2 that edge is T0+48.
- done is asserted for exactly one cycle. start in the DONE cycle is ignored. start is accepted from the following IDLE cycle.
- Outputs are registered. resp is sampled only at settle-end edges and may glitch at any other time.

## Test plan
- Reset: hold rst 2 cycles after random activity → probe=0, busy=0, done=0, mask=0, ones=0, match=0, m_valid=0.
- Nominal: resp driven by the lab-1 target function, SETTLE=2, m_ready=1, start pulse at T0.
  - done at cycle after T0+48.
  - mask=16'h56E2, ones=8, match=1.
  - m_code accepted sequence 1,5,6,7,9,10,12,14.
- Backpressure: same stimulus, m_ready low for 5 cycles when the first m_valid rises → m_code stays 1 throughout, no code is skipped or duplicated, done is delayed to T0+53.
- Faulty function: resp forced 1 for probe==0, otherwise the target function → mask=16'h56E3, ones=9, match=0, first m_code=0.
- All-zero and all-one functions: resp=0 → ones=0, m_valid never high, done at T0+48. resp=1 → mask=16'hFFFF, ones=16, codes 0..15 in order.
- Control corners:
  - start re-pulsed mid-SWEEP → no effect on timing or results.
  - rst asserted while probe==7 → IDLE next cycle, all outputs 0.
  - A fresh start after that rst reproduces the nominal results exactly.
